// File: rtl/sprite_motion.sv
// Bouncing sprite position generator: steps a sprite once every FRAME_DIV enabled
// frames and reflects it off the screen edges, flagging each reversal.
module sprite_motion #(
    parameter int CORDW     = 16,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int X_INIT    = 32,
    parameter int Y_INIT    = 16,
    parameter int FRAME_DIV = 1,
    parameter int SPEEDW    = 4
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    frame,
    input  logic                    en,
    input  logic [SPEEDW-1:0]       speed_x,
    input  logic [SPEEDW-1:0]       speed_y,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic                    bounce,
    output logic                    corner
);

    localparam int CW1  = CORDW + 1;
    localparam int XMAX = H_RES - SPR_W;
    localparam int YMAX = V_RES - SPR_H;
    localparam int DIVW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic signed [CORDW:0] XMAX_W = CW1'(XMAX);
    localparam logic signed [CORDW:0] YMAX_W = CW1'(YMAX);
    localparam logic signed [CORDW:0] ZERO_W = '0;
    localparam logic [DIVW-1:0]       DIV_LAST = DIVW'(FRAME_DIV - 1);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [DIVW-1:0]         r_div;
    logic signed [CORDW-1:0] r_sprx;
    logic signed [CORDW-1:0] r_spry;
    logic                    r_dir_x;
    logic                    r_dir_y;
    logic                    r_bounce;
    logic                    r_corner;

    logic                    w_step;
    logic                    w_move;
    logic signed [CORDW:0]   w_sx_ext;
    logic signed [CORDW:0]   w_sy_ext;
    logic signed [CORDW:0]   w_x_ext;
    logic signed [CORDW:0]   w_y_ext;
    logic signed [CORDW:0]   w_x_cand;
    logic signed [CORDW:0]   w_y_cand;
    logic                    w_x_hit;
    logic                    w_y_hit;
    logic signed [CORDW-1:0] w_x_next;
    logic signed [CORDW-1:0] w_y_next;

    // Assert passes straight through; release is retimed so the datapath leaves reset cleanly.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_step = frame & en;
    assign w_move = w_step & (r_div == DIV_LAST);

    // Candidates carry one extra bit so pos+speed near the top of the range cannot wrap.
    assign w_sx_ext = {{(CW1-SPEEDW){1'b0}}, speed_x};
    assign w_sy_ext = {{(CW1-SPEEDW){1'b0}}, speed_y};
    assign w_x_ext  = {r_sprx[CORDW-1], r_sprx};
    assign w_y_ext  = {r_spry[CORDW-1], r_spry};

    assign w_x_cand = r_dir_x ? (w_x_ext - w_sx_ext) : (w_x_ext + w_sx_ext);
    assign w_y_cand = r_dir_y ? (w_y_ext - w_sy_ext) : (w_y_ext + w_sy_ext);

    assign w_x_hit = (speed_x != '0) &&
                     (r_dir_x ? (w_x_cand <= ZERO_W) : (w_x_cand >= XMAX_W));
    assign w_y_hit = (speed_y != '0) &&
                     (r_dir_y ? (w_y_cand <= ZERO_W) : (w_y_cand >= YMAX_W));

    assign w_x_next = w_x_hit ? (r_dir_x ? '0 : XMAX_W[CORDW-1:0]) : w_x_cand[CORDW-1:0];
    assign w_y_next = w_y_hit ? (r_dir_y ? '0 : YMAX_W[CORDW-1:0]) : w_y_cand[CORDW-1:0];

    always_ff @(posedge clk_pix or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div    <= '0;
            r_sprx   <= CORDW'(X_INIT);
            r_spry   <= CORDW'(Y_INIT);
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
        end else begin
            r_bounce <= 1'b0;
            r_corner <= 1'b0;
            if (w_step) begin
                r_div <= w_move ? '0 : r_div + 1'b1;
            end
            if (w_move) begin
                r_sprx   <= w_x_next;
                r_spry   <= w_y_next;
                r_dir_x  <= w_x_hit ? ~r_dir_x : r_dir_x;
                r_dir_y  <= w_y_hit ? ~r_dir_y : r_dir_y;
                r_bounce <= w_x_hit | w_y_hit;
                r_corner <= w_x_hit & w_y_hit;
            end
        end
    end

    assign sprx   = r_sprx;
    assign spry   = r_spry;
    assign dir_x  = r_dir_x;
    assign dir_y  = r_dir_y;
    assign bounce = r_bounce;
    assign corner = r_corner;

endmodule

// File: doc/sprite_motion.md
SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 SHALL have parameter CORDW, default 16, signed coordinate width in bits.
REQ-002 SHALL have parameter H_RES, default 640, active horizontal pixels.
REQ-003 SHALL have parameter V_RES, default 480, active vertical lines.
REQ-004 SHALL have parameter SPR_W, default 64, sprite width on screen after scaling, in pixels.
REQ-005 SHALL have parameter SPR_H, default 64, sprite height on screen after scaling, in lines.
REQ-006 SHALL have parameter X_INIT, default 32, reset horizontal position.
REQ-007 SHALL have parameter Y_INIT, default 16, reset vertical position.
REQ-008 SHALL have parameter FRAME_DIV, default 1, number of frames per move step (>=1).
REQ-009 SHALL have parameter SPEEDW, default 4, speed input width in bits.
REQ-010 SHALL have port clk_pix  input  1  pixel clock; the only clock.
REQ-011 SHALL have port rst_pix_n  input  1  reset, asynchronous assert, active-low.
REQ-012 SHALL have port frame  input  1  one-cycle pulse at start of frame, from display timing.
REQ-013 SHALL have port en  input  1  motion enable.
REQ-014 SHALL have port speed_x  input  SPEEDW  unsigned horizontal step, in pixels per move.
REQ-015 SHALL have port speed_y  input  SPEEDW  unsigned vertical step, in lines per move.
REQ-016 SHALL have port sprx  output  CORDW signed  sprite left edge, registered.
REQ-017 SHALL have port spry  output  CORDW signed  sprite top edge, registered.
REQ-018 SHALL have port dir_x  output  1  0 = moving right (+), 1 = moving left (-).
REQ-019 SHALL have port dir_y  output  1  0 = moving down (+), 1 = moving up (-).
REQ-020 SHALL have port bounce  output  1  one-cycle pulse when any axis reverses direction.
REQ-021 SHALL have port corner  output  1  one-cycle pulse when both axes reverse on the same move.

Function
REQ-022 SHALL define XMAX = H_RES-SPR_W and YMAX = V_RES-SPR_H; parameters SHALL satisfy 0<=X_INIT<=XMAX and 0<=Y_INIT<=YMAX.
REQ-023 SHALL keep a frame divider counter 0..FRAME_DIV-1 that advances only on a cycle where frame=1 and en=1.
REQ-024 SHALL perform a move on the frame=1, en=1 cycle where the divider equals FRAME_DIV-1; the divider wraps to 0 on that cycle.
REQ-025 SHALL register new sprx/spry/dir/bounce/corner values so they are visible exactly 1 clk_pix cycle after the qualifying frame pulse; outputs SHALL hold between moves.
REQ-026 SHALL sample speed_x/speed_y only on the move cycle.
REQ-027 SHALL compute candidate positions in CORDW+1 bits so no intermediate value overflows.
REQ-028 On a + move, if pos+speed >= MAX: pos <= MAX, dir <= 1, axis bounces; otherwise pos <= pos+speed.
REQ-029 On a - move, if pos-speed <= 0: pos <= 0, dir <= 0, axis bounces; otherwise pos <= pos-speed.
REQ-030 Speed 0 on an axis SHALL leave that axis unchanged with no bounce, even when it sits at an edge.
REQ-031 bounce SHALL be 1 for one cycle if either axis bounced; corner SHALL be 1 for that cycle only if both bounced; both SHALL be 0 on all other cycles.
REQ-032 With en=0, frame pulses SHALL be ignored and the divider SHALL hold its value; re-enabling SHALL resume from the held count.
REQ-033 frame pulses arriving while rst_pix_n=0 SHALL have no effect.

Reset
REQ-034 rst_pix_n=0 SHALL immediately, without a clock edge, set sprx=X_INIT, spry=Y_INIT, dir_x=0, dir_y=0, bounce=0, corner=0, and divider=0.
REQ-035 Reset release SHALL be synchronised to clk_pix; the first move SHALL need a full FRAME_DIV frames after release.

Verification
REQ-036 Reset: rst_pix_n=0 while pulsing frame -> sprx=32, spry=16, dir=0/0, bounce=0; release with no frame pulse -> outputs unchanged.
REQ-037 Step: FRAME_DIV=1, en=1, speed 2/1, one frame pulse -> next cycle sprx=34, spry=17, bounce=0.
REQ-038 Right edge: sprx=574, XMAX=576, speed_x=4 -> sprx=576, dir_x=1, bounce=1 for one cycle, corner=0; next move -> sprx=572.
REQ-039 Corner: sprx=574, spry=414, YMAX=416, speed 4/4 -> sprx=576, spry=416, both dirs=1, bounce=1, corner=1 for one cycle.
REQ-040 Divider/enable: FRAME_DIV=3, two pulses, en=0 plus two pulses, en=1 plus one pulse -> exactly one move, occurring after the fifth pulse.
REQ-041 Async reset mid-run: sprx=100 and dir_x=1, drop rst_pix_n between clock edges -> sprx=32 and dir_x=0 before the next clk_pix edge.
